// File: rtl/period_chk_pkg.sv
// ============================================================================
// Module  : period_chk_pkg
// Brief   : Shared state enum, default sizes and the counter successor function
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

package period_chk_pkg;

   localparam int CNT_W_DEF    = 8;
   localparam int WRAP_VAL_DEF = 10;

   typedef enum logic [1:0] {
      INIT = 2'd0,
      RUN  = 2'd1,
      HALT = 2'd2
   } state_e;

   // Value the counter must show one clock after showing val with enable en.
   function automatic logic [31:0] nxt_val(input logic [31:0] val,
                                           input logic        en,
                                           input logic [31:0] wrap = WRAP_VAL_DEF);
      if (!en) return '0;
      return (val == wrap) ? '0 : val + 32'd1;
   endfunction

endpackage

`default_nettype wire

// File: rtl/period_checker_evt_fifo.sv
// ============================================================================
// Module  : evt_fifo
// Brief   : Synchronous FIFO with async flush; output reads 0 while empty
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

module evt_fifo #(
   parameter int WIDTH = 16,
   parameter int DEPTH = 4
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             wr_en,
   input  logic [WIDTH-1:0] wr_data,
   input  logic             rd_en,
   output logic [WIDTH-1:0] rd_data,
   output logic             full,
   output logic             empty
);

   localparam int AW    = $clog2(DEPTH);
   localparam int PTR_W = AW + 1;

   logic [WIDTH-1:0] mem_q [DEPTH];
   logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
   logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
   logic             do_wr, do_rd;

   assign empty = (wr_ptr_q == rd_ptr_q);
   assign full  = (wr_ptr_q[AW] != rd_ptr_q[AW]) &&
                  (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);

   // A read frees the slot in the same edge, so a write into a full queue is kept.
   assign do_rd = rd_en && !empty;
   assign do_wr = wr_en && (!full || do_rd);

   always_comb begin
      wr_ptr_d = wr_ptr_q;
      rd_ptr_d = rd_ptr_q;
      if (do_wr) wr_ptr_d = wr_ptr_q + PTR_W'(1);
      if (do_rd) rd_ptr_d = rd_ptr_q + PTR_W'(1);
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
      end else begin
         wr_ptr_q <= wr_ptr_d;
         rd_ptr_q <= rd_ptr_d;
      end
   end

   always_ff @(posedge clk) begin
      if (do_wr) mem_q[wr_ptr_q[AW-1:0]] <= wr_data;
   end

   assign rd_data = empty ? '0 : mem_q[rd_ptr_q[AW-1:0]];

endmodule

`default_nettype wire

// File: rtl/period_checker.sv
// ============================================================================
// Module  : period_checker
// Brief   : Sequence checker and period event queue for a modulo counter.
//           Optional mismatch capture ports: define PERIOD_CHK_CAPTURE_EN.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

module period_checker
   import period_chk_pkg::*;
#(
   parameter int CNT_W      = CNT_W_DEF,
   parameter int WRAP_VAL   = WRAP_VAL_DEF,
   parameter int PCNT_W     = 16,
   parameter int FIFO_DEPTH = 4
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              cnt_en,
   input  logic [CNT_W-1:0]  cnt_val,
   input  logic              err_clr,
   output logic              evt_valid,
   input  logic              evt_ready,
   output logic [PCNT_W-1:0] evt_period,
   output logic [PCNT_W-1:0] period_cnt,
   output logic              err,
   output logic              ovf
`ifdef PERIOD_CHK_CAPTURE_EN
   ,
   output logic [CNT_W-1:0]  err_exp,
   output logic [CNT_W-1:0]  err_act
`endif
);

   localparam logic [CNT_W-1:0] WRAP_C = CNT_W'(WRAP_VAL);

   state_e             state_q, state_d;
   logic               prev_en_q;
   logic [CNT_W-1:0]   prev_val_q;
   logic [PCNT_W-1:0]  period_q, period_d;
   logic               err_q, err_d;
   logic               ovf_q, ovf_d;

   logic [CNT_W-1:0]   exp_val;
   logic               mismatch;
   logic               rollover;
   logic               push;
   logic               fifo_pop;
   logic               fifo_full;
   logic               fifo_empty;

   assign exp_val  = CNT_W'(nxt_val(32'(prev_val_q), prev_en_q, 32'(WRAP_VAL)));
   assign mismatch = (cnt_val != exp_val) || (cnt_val > WRAP_C);
   assign rollover = prev_en_q && (prev_val_q == WRAP_C) && (cnt_val == '0);
   assign fifo_pop = evt_valid && evt_ready;

   always_comb begin
      state_d  = state_q;
      period_d = period_q;
      err_d    = err_q;
      ovf_d    = ovf_q;
      push     = 1'b0;
      case (state_q)
         INIT: begin
            // No history yet: only a zero start value is trusted.
            if (cnt_val != '0) begin
               err_d   = 1'b1;
               state_d = HALT;
            end else begin
               state_d = RUN;
            end
         end
         RUN: begin
            if (err_clr) ovf_d = 1'b0;
            if (mismatch) begin
               err_d   = 1'b1;
               state_d = HALT;
            end else if (rollover) begin
               period_d = period_q + PCNT_W'(1);
               push     = 1'b1;
            end
         end
         HALT: begin
            if (err_clr) begin
               state_d = INIT;
               err_d   = 1'b0;
               ovf_d   = 1'b0;
            end
         end
         default: state_d = INIT;
      endcase
      if (push && fifo_full && !fifo_pop) ovf_d = 1'b1;
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q    <= INIT;
         prev_en_q  <= 1'b0;
         prev_val_q <= '0;
         period_q   <= '0;
         err_q      <= 1'b0;
         ovf_q      <= 1'b0;
      end else begin
         state_q    <= state_d;
         prev_en_q  <= cnt_en;
         prev_val_q <= cnt_val;
         period_q   <= period_d;
         err_q      <= err_d;
         ovf_q      <= ovf_d;
      end
   end

   evt_fifo #(
      .WIDTH (PCNT_W),
      .DEPTH (FIFO_DEPTH)
   ) u_evt_fifo (
      .clk     (clk),
      .rst     (rst),
      .wr_en   (push),
      .wr_data (period_d),
      .rd_en   (fifo_pop),
      .rd_data (evt_period),
      .full    (fifo_full),
      .empty   (fifo_empty)
   );

   assign evt_valid  = !fifo_empty;
   assign period_cnt = period_q;
   assign err        = err_q;
   assign ovf        = ovf_q;

`ifdef PERIOD_CHK_CAPTURE_EN
   logic [CNT_W-1:0] err_exp_q, err_exp_d;
   logic [CNT_W-1:0] err_act_q, err_act_d;

   // Entering HALT is always the first mismatch since the last clear.
   always_comb begin
      err_exp_d = err_exp_q;
      err_act_d = err_act_q;
      if ((state_q != HALT) && (state_d == HALT)) begin
         err_exp_d = (state_q == INIT) ? '0 : exp_val;
         err_act_d = cnt_val;
      end else if ((state_q == HALT) && (state_d == INIT)) begin
         err_exp_d = '0;
         err_act_d = '0;
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         err_exp_q <= '0;
         err_act_q <= '0;
      end else begin
         err_exp_q <= err_exp_d;
         err_act_q <= err_act_d;
      end
   end

   assign err_exp = err_exp_q;
   assign err_act = err_act_q;
`endif

endmodule

`default_nettype wire
